fir_request_sequencer: RTL

Host-side initiator for the FIR filter controller's dr/lc/modwait handshake.
- Buffers incoming samples in a small FIFO and a 4-entry coefficient set.
- Presents samples or coefficients on the shared data bus and drives data_ready/load_coeff with the exact hold timing the controller requires.
- Tracks modwait to detect completion, then returns the filtered result and the error flag to the host.

---
 rtl/fir_request_sequencer_if.sv | 31 +++
 rtl/fir_request_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fir_request_sequencer_if.sv
// Handshake bus between the host-side request sequencer and the FIR controller.
// master (sequencer): drives data_out, data_ready (dr), load_coeff (lc).
// slave  (controller/datapath): drives modwait, err and the result word fir_in.
interface fir_request_sequencer_if #(
    parameter int unsigned DATA_W = 16
);
    logic [DATA_W-1:0] data_out;
    logic              data_ready;
    logic              load_coeff;
    logic              modwait;
    logic              err;
    logic [DATA_W-1:0] fir_in;

    modport master (
        output data_out,
        output data_ready,
        output load_coeff,
        input  modwait,
        input  err,
        input  fir_in
    );

    modport slave (
        input  data_out,
        input  data_ready,
        input  load_coeff,
        output modwait,
        output err,
        output fir_in
    );
endinterface

// File: rtl/fir_request_sequencer.sv
// Host-side initiator for the FIR controller dr/lc/modwait handshake.
// Queues samples in a DEPTH-entry FIFO and a 4-slot coefficient set, issues
// them to the controller over the bus interface, and returns each filtered
// result with its error flag.
// Ports:
//   clk, n_reset            clock, asynchronous active-low reset
//   sample_in/sample_wr     host sample push
//   coef_in/coef_wr         host coefficient write (slots 0..3 in order)
//   bus (master)            data_out, data_ready, load_coeff / modwait, err, fir_in
//   result_out/err_out      last captured result and error flag
//   result_valid            one-cycle completion pulse
//   sample_full             FIFO holds DEPTH entries (combinational)
//   sample_drop             one-cycle pulse for a push lost to a full FIFO
//   coef_busy               coefficient set full/being loaded; writes ignored
module fir_request_sequencer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic [DATA_W-1:0]     sample_in,
    input  logic                  sample_wr,
    input  logic [DATA_W-1:0]     coef_in,
    input  logic                  coef_wr,
    fir_request_sequencer_if.master bus,
    output logic [DATA_W-1:0]     result_out,
    output logic                  result_valid,
    output logic                  err_out,
    output logic                  sample_full,
    output logic                  sample_drop,
    output logic                  coef_busy
);
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned PTR_W  = AW + 1;
    localparam int unsigned NCOEF  = 4;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned IDX_W  = 2;

    typedef enum logic [2:0] {
        IDLE,
        S_REQ,
        S_WAIT,
        C_REQ,
        C_DONE
    } state_t;

    state_t             state;
    logic [DATA_W-1:0]  mem  [DEPTH];
    logic [DATA_W-1:0]  coef [NCOEF];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   coef_cnt;
    logic [IDX_W-1:0]   idx;

    logic sample_empty;
    logic pop;
    logic push;
    logic coef_we;

    // FIFO status and the accepted push/pop/write strobes
    always_comb begin
        sample_empty = (wr_ptr == rd_ptr);
        sample_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop          = (state == S_REQ) && bus.modwait;
        // A pop in the same cycle frees the slot the push lands in
        push         = sample_wr && (!sample_full || pop);
        coef_we      = coef_wr && (coef_cnt != CNT_W'(NCOEF));
    end

    // Storage arrays carry no reset; validity is tracked by pointers/count
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= sample_in;
        end
        if (coef_we) begin
            coef[coef_cnt[IDX_W-1:0]] <= coef_in;
        end
    end

    // Request FSM, FIFO pointers, coefficient count and registered outputs
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            coef_cnt       <= '0;
            idx            <= '0;
            bus.data_out   <= '0;
            bus.data_ready <= 1'b0;
            bus.load_coeff <= 1'b0;
            result_out     <= '0;
            result_valid   <= 1'b0;
            err_out        <= 1'b0;
            sample_drop    <= 1'b0;
            coef_busy      <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            sample_drop  <= sample_wr && sample_full && !pop;

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (coef_we) begin
                coef_cnt <= coef_cnt + CNT_W'(1);
                if (coef_cnt == CNT_W'(NCOEF - 1)) begin
                    coef_busy <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (coef_cnt == CNT_W'(NCOEF)) begin
                        state          <= C_REQ;
                        idx            <= '0;
                        bus.load_coeff <= 1'b1;
                        bus.data_out   <= coef[0];
                    end else if (!sample_empty) begin
                        state          <= S_REQ;
                        bus.data_ready <= 1'b1;
                        bus.data_out   <= mem[rd_ptr[AW-1:0]];
                    end
                end
                // dr stays up until the controller reports STORE via modwait
                S_REQ: begin
                    if (bus.modwait) begin
                        state          <= S_WAIT;
                        bus.data_ready <= 1'b0;
                    end
                end
                // modwait low again means the result (or an abort) is ready
                S_WAIT: begin
                    if (!bus.modwait) begin
                        state        <= IDLE;
                        result_out   <= bus.fir_in;
                        err_out      <= bus.err;
                        result_valid <= 1'b1;
                        bus.data_out <= '0;
                    end
                end
                // One modwait-high cycle per controller COEF state advances idx
                C_REQ: begin
                    if (bus.modwait) begin
                        if (idx == IDX_W'(NCOEF - 1)) begin
                            state          <= C_DONE;
                            bus.load_coeff <= 1'b0;
                        end else begin
                            idx          <= idx + IDX_W'(1);
                            bus.data_out <= coef[idx + IDX_W'(1)];
                        end
                    end
                end
                C_DONE: begin
                    if (!bus.modwait) begin
                        state        <= IDLE;
                        coef_cnt     <= '0;
                        coef_busy    <= 1'b0;
                        bus.data_out <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
